// File: rtl/alimentador_linhas.sv
// alimentador_linhas: read engine for the signature core.
// Issues in-order line reads starting at a base address. Responses are buffered
// in a small FIFO and handed to the core with a valid/ready handshake.
// Handshake rule, used on every interface of this block: a transfer happens on
// a rising edge where valid and ready are both 1. While valid is 1 and ready
// is 0, valid and the payload it qualifies hold their values.
module alimentador_linhas #(
  parameter int LINE_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic [ADDR_W-1:0] end_base,
  input  logic [CNT_W-1:0]  num_linhas,
  output logic              ocupado,
  output logic              concluido,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_valid,
  input  logic [LINE_W-1:0] mem_dados,
  output logic              linha_valida,
  output logic [LINE_W-1:0] linha_cache,
  output logic [ADDR_W-1:0] endereco,
  input  logic              linha_pronta,
  output logic [1:0]        estado
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int SW    = CW + 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    DRENA  = 2'd2,
    FIM    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0]        req_addr;
  logic [ADDR_W-1:0]        rsp_addr;
  logic [CNT_W-1:0]         req_rest;
  logic [CNT_W-1:0]         out_rest;
  logic [CW-1:0]            pend;
  logic [CW-1:0]            fifo_cnt;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [ADDR_W+LINE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_W+LINE_W-1:0] head;

  logic start;
  logic credit;
  logic grant;
  logic push;
  logic pop;

  // Credits count both in-flight requests and buffered lines, so every granted
  // request already owns a FIFO slot and a push can never find the FIFO full.
  // Without a grant the sum never grows, so mem_req holds until granted.
  assign start    = (state == OCIOSO) && inicio;
  assign credit   = ({1'b0, pend} + {1'b0, fifo_cnt}) < SW'(FIFO_DEPTH);
  assign mem_req  = (state == BUSCA) && credit;
  assign mem_addr = req_addr;
  assign grant    = mem_req && mem_gnt;
  assign push     = mem_valid && (pend != '0);
  assign pop      = linha_valida && linha_pronta;

  // Head entry is gated so the payload reads as zero whenever nothing is valid.
  assign head         = fifo_mem[rd_ptr];
  assign linha_valida = (fifo_cnt != '0);
  assign linha_cache  = linha_valida ? head[LINE_W-1:0] : '0;
  assign endereco     = linha_valida ? head[ADDR_W+LINE_W-1:LINE_W] : '0;

  assign ocupado   = (state == BUSCA) || (state == DRENA);
  assign concluido = (state == FIM);
  assign estado    = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= OCIOSO;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO: if (inicio) state_nxt = (num_linhas != '0) ? BUSCA : FIM;
      BUSCA:  if (grant && (req_rest == CNT_W'(1))) state_nxt = DRENA;
      DRENA:  if (pop && (out_rest == CNT_W'(1))) state_nxt = FIM;
      FIM:    state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
  end

  // Address/count tracking, outstanding-request count and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_addr <= '0;
      rsp_addr <= '0;
      req_rest <= '0;
      out_rest <= '0;
      pend     <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (start) begin
        req_addr <= end_base;
        req_rest <= num_linhas;
        out_rest <= num_linhas;
      end else begin
        if (grant) begin
          req_addr <= req_addr + ADDR_W'(LINE_BYTES);
          req_rest <= req_rest - CNT_W'(1);
        end
        if (pop) out_rest <= out_rest - CNT_W'(1);
      end

      if (start)     rsp_addr <= end_base;
      else if (push) rsp_addr <= rsp_addr + ADDR_W'(LINE_BYTES);

      case ({grant, push})
        2'b10:   pend <= pend + CW'(1);
        2'b01:   pend <= pend - CW'(1);
        default: pend <= pend;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Response storage; contents need no reset because the head is gated by the count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {rsp_addr, mem_dados};
  end

endmodule

// File: tb/tb_alimentador_linhas.sv
// Testbench for alimentador_linhas: directed jobs against a latency-modelled memory
// and a scoreboard of expected line addresses/data.
module tb_alimentador_linhas;

  typedef logic [575:0] chk_t;

  logic         clk;
  logic         reset;
  logic         inicio;
  logic [63:0]  end_base;
  logic [31:0]  num_linhas;
  logic         ocupado;
  logic         concluido;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_valid;
  logic [511:0] mem_dados;
  logic         linha_valida;
  logic [511:0] linha_cache;
  logic [63:0]  endereco;
  logic         linha_pronta;
  logic [1:0]   estado;

  int checks   = 0;
  int failures = 0;
  int grants   = 0;
  int pops     = 0;
  int conc_cnt = 0;
  int req_cycles = 0;
  int cyc      = 0;
  int lat      = 2;

  logic [63:0]  exp_q[$];
  logic [63:0]  rq_addr[$];
  int           rq_due[$];
  logic [63:0]  gnt_log[$];
  logic         prev_stall = 1'b0;
  logic [63:0]  prev_addr;
  logic [511:0] prev_data;

  alimentador_linhas dut (
    .clk(clk), .reset(reset), .inicio(inicio), .end_base(end_base),
    .num_linhas(num_linhas), .ocupado(ocupado), .concluido(concluido),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_valid(mem_valid), .mem_dados(mem_dados), .linha_valida(linha_valida),
    .linha_cache(linha_cache), .endereco(endereco), .linha_pronta(linha_pronta),
    .estado(estado)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] line_of(input logic [63:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic check(input string tag, input chk_t obs, input chk_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ocupado"},   chk_t'(ocupado),      chk_t'(0));
    check({tag, "_concluido"}, chk_t'(concluido),    chk_t'(0));
    check({tag, "_mem_req"},   chk_t'(mem_req),      chk_t'(0));
    check({tag, "_mem_addr"},  chk_t'(mem_addr),     chk_t'(0));
    check({tag, "_valida"},    chk_t'(linha_valida), chk_t'(0));
    check({tag, "_cache"},     chk_t'(linha_cache),  chk_t'(0));
    check({tag, "_endereco"},  chk_t'(endereco),     chk_t'(0));
    check({tag, "_estado"},    chk_t'(estado),       chk_t'(0));
  endtask

  // Pulse inicio for one cycle and queue the lines the job should produce.
  task automatic start_job(input logic [63:0] base, input int n);
    logic [63:0] a;
    @(negedge clk);
    inicio = 1'b1; end_base = base; num_linhas = n;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 64'd64;
    end
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0;
    int n;
    c0 = conc_cnt;
    n = 0;
    while (conc_cnt == c0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, chk_t'(conc_cnt != c0), chk_t'(1));
  endtask

  // Memory model, scoreboard and stall-stability monitor; samples 2 time units after negedge.
  initial begin
    logic [63:0] a;
    mem_valid = 1'b0;
    mem_dados = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (reset) begin
        if (mem_req && mem_gnt) begin
          rq_addr.push_back(mem_addr);
          rq_due.push_back(cyc + lat);
          gnt_log.push_back(mem_addr);
          grants++;
        end
        if (linha_valida && linha_pronta) begin
          pops++;
          check("line_expected", chk_t'(exp_q.size() != 0), chk_t'(1));
          if (exp_q.size() != 0) begin
            a = exp_q.pop_front();
            check("endereco", chk_t'(endereco), chk_t'(a));
            check("linha_cache", chk_t'(linha_cache), chk_t'(line_of(a)));
          end
        end
        if (prev_stall) begin
          check("stall_valida", chk_t'(linha_valida), chk_t'(1));
          check("stall_endereco", chk_t'(endereco), chk_t'(prev_addr));
          check("stall_cache", chk_t'(linha_cache), chk_t'(prev_data));
        end
        prev_stall = linha_valida && !linha_pronta;
        prev_addr  = endereco;
        prev_data  = linha_cache;
        if (concluido) conc_cnt++;
        if (mem_req) req_cycles++;
      end else begin
        prev_stall = 1'b0;
      end
      if (rq_due.size() != 0 && rq_due[0] <= cyc) begin
        mem_valid = 1'b1;
        mem_dados = line_of(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end else begin
        mem_valid = 1'b0;
        mem_dados = '0;
      end
    end
  end

  // Directed tests.
  initial begin
    int c0;
    int p0;
    int g0;
    int r0;
    int n;
    reset = 1'b0; inicio = 1'b0; end_base = '0; num_linhas = '0;
    mem_gnt = 1'b1; linha_pronta = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1: ready always high, 3 lines from 0x1000.
    c0 = conc_cnt; p0 = pops;
    start_job(64'h1000, 3);
    wait_done("t1", 100);
    repeat (3) @(negedge clk);
    #3;
    check("t1_pops", chk_t'(pops - p0), chk_t'(3));
    check("t1_concluido_pulses", chk_t'(conc_cnt - c0), chk_t'(1));
    check("t1_exp_left", chk_t'(exp_q.size()), chk_t'(0));
    check("t1_ocupado", chk_t'(ocupado), chk_t'(0));

    // 2: zero-length job.
    c0 = conc_cnt; r0 = req_cycles;
    start_job(64'h7000, 0);
    #1;
    check("t2_concluido", chk_t'(concluido), chk_t'(1));
    check("t2_ocupado", chk_t'(ocupado), chk_t'(0));
    @(negedge clk);
    #1;
    check("t2_concluido_end", chk_t'(concluido), chk_t'(0));
    check("t2_ocupado_end", chk_t'(ocupado), chk_t'(0));
    repeat (3) @(negedge clk);
    #3;
    check("t2_no_mem_req", chk_t'(req_cycles - r0), chk_t'(0));
    check("t2_concluido_pulses", chk_t'(conc_cnt - c0), chk_t'(1));

    // 3: backpressure, 8 lines with the core stalled for 20 cycles.
    linha_pronta = 1'b0;
    g0 = grants; p0 = pops;
    start_job(64'h2000, 8);
    repeat (20) @(negedge clk);
    #3;
    check("t3_grants_before_pop", chk_t'(grants - g0), chk_t'(4));
    check("t3_no_pop", chk_t'(pops - p0), chk_t'(0));
    check("t3_valida", chk_t'(linha_valida), chk_t'(1));
    check("t3_head_addr", chk_t'(endereco), chk_t'(64'h2000));
    @(negedge clk);
    linha_pronta = 1'b1;
    wait_done("t3", 200);
    repeat (3) @(negedge clk);
    #3;
    check("t3_pops", chk_t'(pops - p0), chk_t'(8));
    check("t3_exp_left", chk_t'(exp_q.size()), chk_t'(0));

    // 4: address wrap past all-ones.
    gnt_log.delete();
    start_job(64'hFFFF_FFFF_FFFF_FFC0, 2);
    wait_done("t4", 100);
    repeat (2) @(negedge clk);
    #3;
    check("t4_grants", chk_t'(gnt_log.size()), chk_t'(2));
    if (gnt_log.size() >= 2) begin
      check("t4_addr0", chk_t'(gnt_log[0]), chk_t'(64'hFFFF_FFFF_FFFF_FFC0));
      check("t4_addr1", chk_t'(gnt_log[1]), chk_t'(64'h0));
    end

    // 5: second inicio while busy is ignored.
    c0 = conc_cnt; p0 = pops;
    start_job(64'h3000, 4);
    @(negedge clk);
    inicio = 1'b1; end_base = 64'h9000; num_linhas = 5;
    @(negedge clk);
    inicio = 1'b0;
    wait_done("t5", 100);
    repeat (12) @(negedge clk);
    #3;
    check("t5_pops", chk_t'(pops - p0), chk_t'(4));
    check("t5_concluido_pulses", chk_t'(conc_cnt - c0), chk_t'(1));
    check("t5_exp_left", chk_t'(exp_q.size()), chk_t'(0));
    check("t5_estado", chk_t'(estado), chk_t'(0));

    // 6: reset with two requests outstanding, stale responses afterwards.
    lat = 4;
    c0 = conc_cnt; g0 = grants;
    start_job(64'h4000, 4);
    n = 0;
    while ((grants - g0) < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_grants", chk_t'(grants - g0), chk_t'(2));
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("t6_after_reset");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("t6_valida_low", chk_t'(linha_valida), chk_t'(0));
    end
    #2;
    check("t6_stale_delivered", chk_t'(rq_addr.size()), chk_t'(0));
    check("t6_no_concluido", chk_t'(conc_cnt - c0), chk_t'(0));
    check_zero("t6_idle");
    lat = 2;

    // Recovery after the abandoned job.
    p0 = pops;
    start_job(64'h5000, 1);
    wait_done("t7", 100);
    repeat (2) @(negedge clk);
    #3;
    check("t7_pops", chk_t'(pops - p0), chk_t'(1));
    check("t7_exp_left", chk_t'(exp_q.size()), chk_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
